// File: rtl/cla_seq32.sv
// Sequential 32-bit adder: one 4-bit carry-lookahead slice reused over 8 nibbles.
// Optional subtract mode is enabled with `define CLA_SEQ_SUB_EN (adds input port sub).

module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

module cla_seq32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
`ifdef CLA_SEQ_SUB_EN
  input  logic        sub,
`endif
  output logic [31:0] s,
  output logic        co,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic              carry_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              sub_reg;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] nib_sum;
  logic       nib_co;
  logic       init_carry;

`ifdef CLA_SEQ_SUB_EN
  // Subtraction is a + ~b + 1, so the initial carry replaces ci.
  assign init_carry = sub ? 1'b1 : ci;
`else
  assign init_carry = ci;
`endif

  always_comb begin
    a_nib = a_reg[{cnt, 2'b00} +: 4];
    b_nib = b_reg[{cnt, 2'b00} +: 4];
    if (sub_reg) begin
      b_nib = ~b_nib;
    end
  end

  cla4 u_cla4 (
    .x    (a_nib),
    .y    (b_nib),
    .cin  (carry_reg),
    .sum  (nib_sum),
    .cout (nib_co)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= EXEC;
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= init_carry;
            cnt       <= 3'd0;
            s         <= '0;
`ifdef CLA_SEQ_SUB_EN
            sub_reg   <= sub;
`else
            sub_reg   <= 1'b0;
`endif
          end
        end
        EXEC: begin
          s[{cnt, 2'b00} +: 4] <= nib_sum;
          carry_reg            <= nib_co;
          cnt                  <= cnt + 3'd1;
          // Last nibble: its carry is the 33rd result bit.
          if (cnt == 3'd7) begin
            co    <= nib_co;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == EXEC);
  assign done = (state == DONE);

endmodule

// File: doc/cla_seq32.md
CLA_SEQ32 -- requirements
Module: cla_seq32

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset: clk (rising edge) and reset_n.
REQ-002 The block SHALL have port clk, input, 1, system clock.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 32, operand A, captured on the accepted start.
REQ-006 The block SHALL have port b, input, 32, operand B, captured on the accepted start.
REQ-007 The block SHALL have port ci, input, 1, carry-in, captured on the accepted start.
REQ-008 The block SHALL have port s, output, 32, registered sum.
REQ-009 The block SHALL have port co, output, 1, registered carry-out of bit 31.
REQ-010 The block SHALL have port busy, output, 1, high while in EXEC.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion strobe.

Function
REQ-012 The datapath SHALL be exactly one cla4 instance, time-shared across 8 nibble slices; no other adder SHALL exist.
REQ-013 The FSM SHALL have states IDLE, EXEC and DONE; the encoding is free.
REQ-014 In IDLE with start=1 at a clk edge, the FSM SHALL go to EXEC, latch a, b and ci, clear the slice counter cnt[2:0] to 0, and clear s to 0.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE, and s and co SHALL hold.
REQ-016 On each EXEC edge, the FSM SHALL write the cla4 sum of a_reg[4cnt+3:4cnt] + b_reg[4cnt+3:4cnt] + carry_reg into s[4cnt+3:4cnt], load carry_reg with the cla4 carry-out, and increment cnt.
REQ-017 On the EXEC edge with cnt=7, the FSM SHALL also load co with the cla4 carry-out, go to DONE, and let cnt wrap to 0.
REQ-018 done SHALL be 1 exactly while in DONE; DONE SHALL last one cycle and then go unconditionally to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the 9th cycle after the start-accept edge.
REQ-020 start in EXEC or DONE SHALL be ignored, with no queuing; operand input changes after acceptance SHALL NOT affect the result.
REQ-021 s and co SHALL hold the final result from DONE until the next accepted start.
REQ-022 The result SHALL be {co,s} = a + b + ci modulo 2^33; all-ones operands with ci=1 SHALL wrap to s=FFFFFFFF, co=1.

Reset
REQ-023 Asserting reset_n low SHALL immediately force state=IDLE, cnt=0, carry_reg=0, a_reg=b_reg=0, s=0, co=0, busy=0, done=0.
REQ-024 A reset during EXEC or DONE SHALL abort the operation with no done pulse; the first start after release SHALL be processed normally.

Configuration
REQ-025 With macro CLA_SEQ_SUB_EN defined, an input port sub (1 bit) SHALL exist and SHALL be captured with the operands.
REQ-026 When CLA_SEQ_SUB_EN is defined and sub=1, the block SHALL use ~b_reg for the b nibbles and force the initial carry_reg to 1 (ci ignored), so that s = a - b and co = 1 when no borrow occurs.
REQ-027 Without CLA_SEQ_SUB_EN, the sub port SHALL NOT exist and the block SHALL perform addition only.

Verification
REQ-028 Reset low mid-EXEC (cycle 4) -> all outputs 0 immediately; no done; the next start with a=1, b=1 gives s=00000002.
REQ-029 a=00000003, b=00000005, ci=0, start -> busy high 8 cycles; done in cycle 9; s=00000008, co=0.
REQ-030 a=FFFFFFFF, b=FFFFFFFF, ci=1 -> s=FFFFFFFF, co=1; a=0000000F, b=00000001, ci=0 -> s=00000010, co=0 (inter-nibble carry).
REQ-031 Start held high for the full operation with operands changed in cycle 3 -> exactly one done, result from the captured operands; a new operation begins the cycle after DONE.
REQ-032 With CLA_SEQ_SUB_EN, sub=1, a=00000005, b=00000007 -> s=FFFFFFFE, co=0; a=7, b=5 -> s=00000002, co=1.
